// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Turns one raw, bouncing push-button into a sequence of NUM_OPERANDS
//   operand-capture strobes, followed by a result-display phase.
//   The button is synchronised, debounced and edge-detected on chip.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   button      raw asynchronous push-button, active high
//   clear       synchronous abort back to operand 0; highest priority
//   save_op     one-hot, single-cycle capture strobe for operand op_idx
//   op_idx      index of the operand awaiting capture (0 while showing)
//   show_result level, high for the whole result-display phase
//   done        single-cycle pulse in the cycle the display phase exits
`timescale 1ns/1ps
module operand_sequencer #(
  parameter int NUM_OPERANDS    = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SHOW_CYCLES     = 0,
  parameter int IDX_W           = $clog2(NUM_OPERANDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    button,
  input  logic                    clear,
  output logic [NUM_OPERANDS-1:0] save_op,
  output logic [IDX_W-1:0]        op_idx,
  output logic                    show_result,
  output logic                    done
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; the show
  // timer only needs to reach SHOW_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((SHOW_CYCLES > 0) ? SHOW_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPERANDS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    SHOW    = 1'b1
  } state_t;

  logic             sync1, sync2;
  logic             deb_level, deb_prev;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;
  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             timeout;

  // Synchroniser, debouncer and rising-edge detector. None of this sees
  // clear, so a press already in flight still lands after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      // deb_cnt counts consecutive samples that disagree with deb_level;
      // any agreeing sample restarts the run, which rejects short glitches.
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      deb_prev <= deb_level;
      press    <= deb_level & ~deb_prev;
    end
  end

  assign timeout = (SHOW_CYCLES > 0) && (state == SHOW) && (timer == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= COLLECT;
      op_idx <= '0;
      timer  <= '0;
    end else if (clear) begin
      state  <= COLLECT;
      op_idx <= '0;
      timer  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (press) begin
            if (op_idx == IDX_LAST) begin
              op_idx <= '0;
              state  <= SHOW;
            end else begin
              op_idx <= op_idx + 1'b1;
            end
          end
        end
        SHOW: begin
          // A press and a timeout in the same cycle make a single exit.
          if (press || timeout) begin
            state <= COLLECT;
            timer <= '0;
          end else if (SHOW_CYCLES > 0) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_comb begin
    save_op = '0;
    if ((state == COLLECT) && press && !clear) begin
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        save_op[i] = (op_idx == IDX_W'(i));
      end
    end
  end

  assign show_result = (state == SHOW);
  assign done        = (state == SHOW) && (press || timeout) && !clear;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: two instances (2 operands / held display and
// 4 operands / 5-cycle auto-exit) share the same button, clear and reset.
// A reference model predicts every output cycle by cycle: debounced presses
// come from "D consecutive equal button samples" plus the fixed pipeline
// latency, and the sequencing from an operand-count/phase view.
`timescale 1ns/1ps
module tb_operand_sequencer;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] so_a;
  logic       idx_a;
  logic       show_a, done_a;
  logic [3:0] so_b;
  logic [1:0] idx_b;
  logic       show_b, done_b;

  always #5 clk = ~clk;

  operand_sequencer #(.NUM_OPERANDS(2), .DEBOUNCE_CYCLES(D), .SHOW_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .button(button), .clear(clear),
    .save_op(so_a), .op_idx(idx_a), .show_result(show_a), .done(done_a));

  operand_sequencer #(.NUM_OPERANDS(4), .DEBOUNCE_CYCLES(D), .SHOW_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .button(button), .clear(clear),
    .save_op(so_b), .op_idx(idx_b), .show_result(show_b), .done(done_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state
  bit press_sched [0:8191];
  int run;
  bit last_b, lvl;
  int phase [2];
  int tmr [2];

  function automatic int nops(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int showc(int d);
    return (d == 0) ? 0 : 5;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0;
      tmr[d]   = 0;
    end
    run = 0;
    last_b = 1'b0;
    lvl = 1'b0;
    foreach (press_sched[i]) press_sched[i] = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, compare outputs of the current
  // cycle, advance the model to the next rising edge, then wait for the
  // next falling edge.
  task automatic step(bit b, bit c);
    bit p, show, to;
    logic [3:0] e_so, o_so;
    logic [3:0] e_idx, o_idx;
    logic e_done, o_done, o_show;
    string sfx;
    button = b;
    clear  = c;
    #1;
    p = press_sched[cyc];
    for (int d = 0; d < 2; d++) begin
      sfx    = (d == 0) ? "a" : "b";
      show   = (phase[d] == nops(d));
      e_so   = (!show && p && !c) ? 4'(1 << phase[d]) : 4'd0;
      e_idx  = show ? 4'd0 : 4'(phase[d]);
      to     = show && (showc(d) > 0) && (tmr[d] == showc(d) - 1);
      e_done = show && (p || to) && !c;
      o_so   = (d == 0) ? {2'b00, so_a} : so_b;
      o_idx  = (d == 0) ? {3'b000, idx_a} : {2'b00, idx_b};
      o_show = (d == 0) ? show_a : show_b;
      o_done = (d == 0) ? done_a : done_b;
      chk({"save_op_", sfx}, o_so, e_so);
      chk({"op_idx_", sfx}, o_idx, e_idx);
      chk({"show_result_", sfx}, {3'b000, o_show}, {3'b000, show});
      chk({"done_", sfx}, {3'b000, o_done}, {3'b000, e_done});
      if (c) begin
        phase[d] = 0;
        tmr[d]   = 0;
      end else if (!show) begin
        if (p) phase[d] = phase[d] + 1;
      end else if (p || to) begin
        phase[d] = 0;
        tmr[d]   = 0;
      end else if (showc(d) > 0) begin
        tmr[d] = tmr[d] + 1;
      end
    end
    // Debounced level follows a run of D equal samples; a rise is seen as
    // a capture four cycles after the sample completing the run.
    if (b == last_b) run++;
    else run = 1;
    last_b = b;
    if (run >= D && b != lvl) begin
      lvl = b;
      if (b) press_sched[cyc + 4] = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(bit b);
    rst_n  = 1'b0;
    button = b;
    clear  = 1'b0;
    #1;
    chk("rst_save_op_a", {2'b00, so_a}, 4'd0);
    chk("rst_save_op_b", so_b, 4'd0);
    chk("rst_op_idx_a", {3'b000, idx_a}, 4'd0);
    chk("rst_op_idx_b", {2'b00, idx_b}, 4'd0);
    chk("rst_show_a", {3'b000, show_a}, 4'd0);
    chk("rst_show_b", {3'b000, show_b}, 4'd0);
    chk("rst_done_a", {3'b000, done_a}, 4'd0);
    chk("rst_done_b", {3'b000, done_b}, 4'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse(int hi, int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, len;
    bit cur;
    @(negedge clk);
    do_reset(1'b0);

    // Clean presses: full sequences on both instances.
    repeat (3) pulse(10, 10);

    // Bouncing press, then a lone short glitch.
    do_reset(1'b0);
    repeat (3) begin
      step(1'b1, 1'b0); step(1'b1, 1'b0);
      step(1'b0, 1'b0); step(1'b0, 1'b0);
    end
    pulse(8, 10);
    pulse(3, 10);

    // Clear coinciding with a press (b at op_idx 2, a in SHOW).
    do_reset(1'b0);
    pulse(10, 10);
    pulse(10, 10);
    pulse(6, 0);
    n = 0;
    while (!press_sched[cyc] && n < 40) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("press_arrival", {3'b000, n < 40}, 4'd1);
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // Four presses then auto-exit of the display phase on b.
    do_reset(1'b0);
    repeat (4) pulse(8, 8);
    repeat (15) step(1'b0, 1'b0);

    // Button held through reset release.
    do_reset(1'b1);
    pulse(12, 10);

    // Reset in the middle of a sequence.
    pulse(10, 10);
    do_reset(1'b0);
    repeat (4) step(1'b0, 1'b0);

    // Random bounces, presses and clears.
    cur = 1'b0;
    n = cyc + 1500;
    while (cyc < n) begin
      cur = ~cur;
      len = $urandom_range(1, 14);
      repeat (len) step(cur, $urandom_range(0, 39) == 0);
    end
    repeat (20) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
